// File: rtl/playlist_sequencer.sv
// Playlist sequencer: play/pause/gap FSM, song index selection (sequential,
// repeat or LFSR shuffle) and beat-restart pulse generation for a tone player.
module playlist_sequencer #(
    parameter logic [15:0] GAP_CYCLES = 16'd8192,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_pause,
    input  logic       next,
    input  logic       prev,
    input  logic       repeat_one,
    input  logic       shuffle,
    input  logic       song_finished,
    output logic [1:0] song_sel,
    output logic       beat_restart,
    output logic       ispause,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  song_sel_q, song_sel_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        beat_restart_q, beat_restart_d;
    logic        ispause_q, ispause_d;
    logic        restart_req_s;
    logic [1:0]  song_fwd_s, song_back_s, song_fin_s;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Shuffle never lands on the song that is currently selected.
    function automatic logic [1:0] shuffle_pick(input logic [7:0] lfsr, input logic [1:0] cur);
        logic [1:0] cand;
        cand = lfsr[1:0];
        if (cand == cur) begin
            return cand + 2'd1;
        end else begin
            return cand;
        end
    endfunction

    // Candidate song indices and next-state / output computation.
    always_comb begin
        song_fwd_s    = shuffle ? shuffle_pick(lfsr_q, song_sel_q) : song_sel_q + 2'd1;
        song_back_s   = song_sel_q - 2'd1;
        song_fin_s    = repeat_one ? song_sel_q : song_fwd_s;
        state_d       = state_q;
        song_sel_d    = song_sel_q;
        gap_cnt_d     = gap_cnt_q;
        restart_req_s = 1'b0;
        lfsr_d        = lfsr_step(lfsr_q);
        case (state_q)
            ST_IDLE: begin
                if (play_pause) begin
                    state_d       = ST_PLAY;
                    restart_req_s = 1'b1;
                end else if (next) begin
                    song_sel_d = song_fwd_s;
                end else if (prev) begin
                    song_sel_d = song_back_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (play_pause) begin
                    state_d = ST_PAUSE;
                end else if (next) begin
                    song_sel_d = song_fwd_s;
                    state_d    = ST_GAP;
                    gap_cnt_d  = GAP_CYCLES - 16'd1;
                end else if (prev) begin
                    song_sel_d = song_back_s;
                    state_d    = ST_GAP;
                    gap_cnt_d  = GAP_CYCLES - 16'd1;
                end else if (song_finished) begin
                    song_sel_d = song_fin_s;
                    state_d    = ST_GAP;
                    gap_cnt_d  = GAP_CYCLES - 16'd1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                // Resuming keeps the beat position, so no restart here.
                if (play_pause) begin
                    state_d = ST_PLAY;
                end else if (next) begin
                    song_sel_d    = song_fwd_s;
                    restart_req_s = 1'b1;
                end else if (prev) begin
                    song_sel_d    = song_back_s;
                    restart_req_s = 1'b1;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_GAP: begin
                if (play_pause) begin
                    state_d       = ST_PAUSE;
                    gap_cnt_d     = 16'd0;
                    restart_req_s = 1'b1;
                end else if (next) begin
                    song_sel_d = song_fwd_s;
                    gap_cnt_d  = GAP_CYCLES - 16'd1;
                end else if (prev) begin
                    song_sel_d = song_back_s;
                    gap_cnt_d  = GAP_CYCLES - 16'd1;
                end else if (gap_cnt_q == 16'd0) begin
                    state_d       = ST_PLAY;
                    restart_req_s = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A restart directly after another one is merged into it.
        beat_restart_d = restart_req_s & ~beat_restart_q;
        ispause_d      = (state_d != ST_PLAY);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            song_sel_q     <= 2'b00;
            gap_cnt_q      <= 16'd0;
            lfsr_q         <= LFSR_SEED;
            beat_restart_q <= 1'b0;
            ispause_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            song_sel_q     <= song_sel_d;
            gap_cnt_q      <= gap_cnt_d;
            lfsr_q         <= lfsr_d;
            beat_restart_q <= beat_restart_d;
            ispause_q      <= ispause_d;
        end
    end

    assign song_sel     = song_sel_q;
    assign beat_restart = beat_restart_q;
    assign ispause      = ispause_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Self-checking bench for playlist_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked each cycle against an event-level model.
module tb_playlist_sequencer;

    localparam logic [15:0] G = 16'd12;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_GAP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play_pause = 1'b0, next = 1'b0, prev = 1'b0;
    logic       repeat_one = 1'b0, shuffle = 1'b0, song_finished = 1'b0;
    logic [1:0] song_sel, state_dbg;
    logic       beat_restart, ispause;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_mode, m_song, m_gap_left;
    logic [7:0] m_lfsr;
    bit         m_restart, m_req;

    playlist_sequencer #(.GAP_CYCLES(G), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
        .repeat_one(repeat_one), .shuffle(shuffle), .song_finished(song_finished),
        .song_sel(song_sel), .beat_restart(beat_restart), .ispause(ispause),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick_next(int cur, bit shuf, logic [7:0] l);
        int c;
        if (!shuf) return (cur + 1) % 4;
        c = int'(l) % 4;
        if (c == cur) c = (c + 1) % 4;
        return c;
    endfunction

    // Model advance for one clock edge, organised by incoming event.
    task automatic model_step();
        m_req = 0;
        if (play_pause) begin
            if (m_mode == M_PLAY) m_mode = M_PAUSE;
            else if (m_mode == M_GAP) begin m_mode = M_PAUSE; m_req = 1; end
            else begin
                if (m_mode == M_IDLE) m_req = 1;
                m_mode = M_PLAY;
            end
        end else if (next || prev) begin
            m_song = next ? pick_next(m_song, shuffle, m_lfsr) : (m_song + 3) % 4;
            if (m_mode == M_PLAY || m_mode == M_GAP) begin
                m_mode = M_GAP;
                m_gap_left = int'(G);
            end else if (m_mode == M_PAUSE) m_req = 1;
        end else if (song_finished && m_mode == M_PLAY) begin
            if (!repeat_one) m_song = pick_next(m_song, shuffle, m_lfsr);
            m_mode = M_GAP;
            m_gap_left = int'(G);
        end else if (m_mode == M_GAP) begin
            if (m_gap_left == 1) begin m_mode = M_PLAY; m_req = 1; end
            else m_gap_left--;
        end
        m_restart = m_req && !m_restart;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    // Compare against the model, then advance it for the upcoming edge.
    always @(negedge clk) begin
        if (!reset) begin
            m_mode = M_IDLE; m_song = 0; m_gap_left = 0; m_lfsr = 8'hA5; m_restart = 0;
        end
        check("mdl_state", int'(state_dbg), m_mode);
        check("mdl_song", int'(song_sel), m_song);
        check("mdl_ispause", int'(ispause), (m_mode != M_PLAY) ? 1 : 0);
        check("mdl_restart", int'(beat_restart), m_restart ? 1 : 0);
        if (reset) model_step();
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gap(output int n);
        n = 0;
        while (state_dbg == 2'd3 && n < 200) begin
            n++;
            step();
        end
    endtask

    int     n;
    int     prior;
    logic [3:0] seen;
    int     r;

    initial begin
        repeat (3) step();
        check("rst_state", int'(state_dbg), 0);
        check("rst_song", int'(song_sel), 0);
        check("rst_ispause", int'(ispause), 1);
        check("rst_restart", int'(beat_restart), 0);
        reset = 1'b1;
        step();
        check("rel_restart", int'(beat_restart), 0);

        play_pause = 1'b1; step(); play_pause = 1'b0;
        check("start_state", int'(state_dbg), 1);
        check("start_restart", int'(beat_restart), 1);
        check("start_ispause", int'(ispause), 0);
        check("start_song", int'(song_sel), 0);
        step();
        check("start_restart_1w", int'(beat_restart), 0);

        play_pause = 1'b1; step(); play_pause = 1'b0;
        check("pause_state", int'(state_dbg), 2);
        prev = 1'b1; step(); prev = 1'b0;
        check("pause_prev_song", int'(song_sel), 3);
        check("pause_prev_restart", int'(beat_restart), 1);
        check("pause_prev_state", int'(state_dbg), 2);
        play_pause = 1'b1; step(); play_pause = 1'b0;
        check("resume_state", int'(state_dbg), 1);
        check("resume_no_restart", int'(beat_restart), 0);

        song_finished = 1'b1; step(); song_finished = 1'b0;
        check("wrap_song", int'(song_sel), 0);
        check("wrap_gap_state", int'(state_dbg), 3);
        check("wrap_gap_ispause", int'(ispause), 1);
        wait_gap(n);
        check("wrap_gap_len", n, int'(G));
        check("wrap_play", int'(state_dbg), 1);
        check("wrap_restart", int'(beat_restart), 1);

        next = 1'b1; step(); next = 1'b0;
        check("play_next_song", int'(song_sel), 1);
        check("play_next_state", int'(state_dbg), 3);
        next = 1'b1; step(); next = 1'b0;
        check("gap_next_song", int'(song_sel), 2);
        wait_gap(n);
        check("gap_reload_len", n, int'(G));

        repeat_one = 1'b1;
        song_finished = 1'b1; step(); song_finished = 1'b0;
        check("rep_song", int'(song_sel), 2);
        check("rep_state", int'(state_dbg), 3);
        wait_gap(n);
        check("rep_gap_len", n, int'(G));
        check("rep_restart", int'(beat_restart), 1);
        repeat_one = 1'b0;

        play_pause = 1'b1; next = 1'b1; step(); play_pause = 1'b0; next = 1'b0;
        check("prio_state", int'(state_dbg), 2);
        check("prio_song", int'(song_sel), 2);

        play_pause = 1'b1; step(); play_pause = 1'b0;
        song_finished = 1'b1; step(); song_finished = 1'b0;
        check("pre_rst_song", int'(song_sel), 3);
        repeat (4) step();
        reset = 1'b0;
        #1;
        check("async_rst_state", int'(state_dbg), 0);
        check("async_rst_song", int'(song_sel), 0);
        check("async_rst_ispause", int'(ispause), 1);
        step();
        reset = 1'b1;
        step();
        check("post_rst_restart", int'(beat_restart), 0);
        check("post_rst_state", int'(state_dbg), 0);

        shuffle = 1'b1;
        seen = 4'b0000;
        for (int i = 0; i < 200; i++) begin
            prior = int'(song_sel);
            next = 1'b1; step(); next = 1'b0;
            check("shuffle_changes", (int'(song_sel) != prior) ? 1 : 0, 1);
            seen[song_sel] = 1'b1;
            repeat ($urandom_range(0, 2)) step();
        end
        check("shuffle_coverage", int'(seen), 15);
        shuffle = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) begin
                repeat_one = 1'($urandom_range(0, 1));
                shuffle    = 1'($urandom_range(0, 1));
            end
            r = $urandom_range(0, 63);
            play_pause    = (r == 0 || r == 6);
            next          = (r == 1 || r == 6 || r == 7);
            prev          = (r == 2 || r == 6 || r == 7);
            song_finished = (r >= 3 && r <= 7) || (r >= 8 && r <= 12);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                step();
                step();
                reset = 1'b1;
            end
            step();
        end
        play_pause = 1'b0; next = 1'b0; prev = 1'b0; song_finished = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
